uart_rx: RTL and testbench

- 8N1 UART receiver. It pairs with the frac_div-clocked transmitter path: frac_div produces a free-running bit clock for TX, but RX needs a bit clock that is phase-aligned to each start edge.
- It embeds its own fractional phase accumulator. The accumulator is re-phased on every start bit so that each bit is sampled at mid-bit.
- Sits between the rxd pad and a byte-consuming client, for example a command parser.

---
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver whose fractional bit clock is re-phased on
// every start edge so that each bit is sampled at mid-bit.
// Ports: clk, reset (sync, active-high), rxd (async, idle high),
//        data/valid/ready byte handshake, overrun and frame_err
//        one-cycle pulses, busy (high outside IDLE).
`timescale 1ns/1ps
module uart_rx #(
    parameter int Width = 22,
    parameter int Incr  = 19327
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    localparam logic [Width-1:0] HALF = {1'b1, {(Width-1){1'b0}}};
    localparam logic [Width-1:0] INC  = Width'(Incr);

    state_e           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [Width-1:0] acc_q, acc_d;
    logic             strobe_q, strobe_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic [Width:0]   sum;
    logic             rxs;

    assign rxs    = sync_q[1];
    assign sync_d = {sync_q[0], rxd};
    assign sum    = {1'b0, acc_q} + {1'b0, INC};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        strobe_d = 1'b0;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ovr_d    = 1'b0;
        ferr_d   = 1'b0;

        // An accept this cycle frees the holding register, so a byte
        // completing in the same cycle is stored rather than dropped.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    // Half-scale load puts the first carry at mid start bit.
                    acc_d   = HALF;
                    state_d = START;
                end
            end
            START: begin
                acc_d    = sum[Width-1:0];
                strobe_d = sum[Width];
                if (strobe_q) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end
                end
            end
            DATA: begin
                acc_d    = sum[Width-1:0];
                strobe_d = sum[Width];
                if (strobe_q) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                acc_d    = sum[Width-1:0];
                strobe_d = sum[Width];
                if (strobe_q) begin
                    if (rxs) begin
                        if (valid_q && !ready) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not look like a new start.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            acc_q    <= '0;
            strobe_q <= 1'b0;
            cnt_q    <= 3'd0;
            shift_q  <= 8'd0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            acc_q    <= acc_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: exercises a fast (Width=3, Incr=1) and a default-rate
// uart_rx against a frame-level model of the expected bytes and pulses.
`timescale 1ns/1ps
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #20 clk = ~clk;

    logic       rxd_s = 1'b1;
    logic       ready_s = 1'b0;
    logic [7:0] data_s;
    logic       valid_s, ovr_s, ferr_s, busy_s;

    logic       rxd_d = 1'b1;
    logic       ready_d = 1'b1;
    logic [7:0] data_d;
    logic       valid_d, ovr_d, ferr_d, busy_d;

    uart_rx #(.Width(3), .Incr(1)) u_s (
        .clk(clk), .reset(reset), .rxd(rxd_s),
        .data(data_s), .valid(valid_s), .ready(ready_s),
        .overrun(ovr_s), .frame_err(ferr_s), .busy(busy_s)
    );

    uart_rx u_d (
        .clk(clk), .reset(reset), .rxd(rxd_d),
        .data(data_d), .valid(valid_d), .ready(ready_d),
        .overrun(ovr_d), .frame_err(ferr_d), .busy(busy_d)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Event monitors: accepted bytes and pulse counts.
    logic [7:0] rx_s[$];
    logic [7:0] rx_d[$];
    int ferr_n_s = 0, ovr_n_s = 0, ferr_n_d = 0, ovr_n_d = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (valid_s && ready_s) rx_s.push_back(data_s);
            if (valid_d && ready_d) rx_d.push_back(data_d);
            if (ferr_s) ferr_n_s++;
            if (ovr_s)  ovr_n_s++;
            if (ferr_d) ferr_n_d++;
            if (ovr_d)  ovr_n_d++;
        end
    end

    // Cycle (counted from the acc load) at which the n-th strobe is seen:
    // smallest k with 2^(w-1) + k*inc >= n * 2^w.
    function automatic int strobe_at(input int w, input int inc,
                                     input int n);
        longint num;
        num = longint'(n) * (longint'(1) << w) - (longint'(1) << (w - 1));
        return int'((num + longint'(inc) - 1) / longint'(inc));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_s(input logic [7:0] b, input logic stop,
                          input int nbits);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rxd_s = f[i];
            tick(8);
        end
    endtask

    task automatic send_d(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_d = f[i];
            #8681;
        end
    endtask

    task automatic measure_s(output int first, output int last,
                             output int n, output int vat);
        int t;
        t = 0;
        first = -1; last = -1; n = 0; vat = -1;
        while (!busy_s && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 200 && vat < 0; k++) begin
            if (u_s.strobe_q) begin
                if (first < 0) first = k;
                last = k;
                n++;
            end
            if (valid_s) vat = k;
            if (vat < 0) @(negedge clk);
        end
    endtask

    task automatic measure_d(output int vat);
        int t;
        t = 0;
        vat = -1;
        while (!busy_d && t < 1000) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 3000 && vat < 0; k++) begin
            if (valid_d) vat = k;
            if (vat < 0) @(negedge clk);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, last, n, vat, base, fb, ob, nbad;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic bad;

        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_valid", valid_s, 0);
        chk("rst_busy", busy_s, 0);
        chk("rst_data", data_s, 0);
        chk("rst_ferr", ferr_s, 0);
        chk("rst_ovr", ovr_s, 0);
        chk("rst_busy_d", busy_d, 0);

        // Default rate, back-to-back 0x55, 0x0F with ready held high.
        base = rx_d.size();
        fork
            begin
                send_d(8'h55);
                send_d(8'h0F);
            end
            measure_d(vat);
        join
        tick(10);
        chk("dflt_valid_at", vat, strobe_at(22, 19327, 10) + 1);
        chk("dflt_count", rx_d.size() - base, 2);
        if (rx_d.size() - base == 2) begin
            chk("dflt_b0", rx_d[base], 8'h55);
            chk("dflt_b1", rx_d[base + 1], 8'h0F);
        end
        chk("dflt_ferr", ferr_n_d, 0);
        chk("dflt_ovr", ovr_n_d, 0);

        // Fast rate: 0xA5 timing, held until accepted.
        ready_s = 1'b0;
        fork
            send_s(8'hA5, 1'b1, 10);
            measure_s(first, last, n, vat);
        join
        chk("a5_first_strobe", first, strobe_at(3, 1, 1));
        chk("a5_last_strobe", last, strobe_at(3, 1, 10));
        chk("a5_strobes", n, 10);
        chk("a5_valid_at", vat, strobe_at(3, 1, 10) + 1);
        chk("a5_data", data_s, 8'hA5);
        chk("a5_valid_held", valid_s, 1);
        ready_s = 1'b1;
        tick(1);
        chk("a5_accept_drop", valid_s, 0);

        // Two-clock glitch is rejected by the start-bit check.
        fb = ferr_n_s;
        base = rx_s.size();
        rxd_s = 1'b0;
        tick(2);
        rxd_s = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy_s) n = 1;
            tick(1);
        end
        chk("glitch_seen", n, 1);
        chk("glitch_busy", busy_s, 0);
        chk("glitch_valid", valid_s, 0);
        chk("glitch_ferr", ferr_n_s - fb, 0);
        chk("glitch_bytes", rx_s.size() - base, 0);

        // Break of 20 bit times: one frame error, then recovery.
        fb = ferr_n_s;
        base = rx_s.size();
        rxd_s = 1'b0;
        tick(160);
        chk("break_ferr", ferr_n_s - fb, 1);
        chk("break_busy", busy_s, 1);
        rxd_s = 1'b1;
        tick(4);
        chk("break_idle", busy_s, 0);
        send_s(8'h3C, 1'b1, 10);
        tick(4);
        chk("break_bytes", rx_s.size() - base, 1);
        if (rx_s.size() > 0) chk("break_3c", rx_s[rx_s.size() - 1], 8'h3C);

        // Overrun: second byte dropped while first is unaccepted.
        ready_s = 1'b0;
        ob = ovr_n_s;
        base = rx_s.size();
        send_s(8'h11, 1'b1, 10);
        send_s(8'h22, 1'b1, 10);
        tick(4);
        chk("ovr_pulses", ovr_n_s - ob, 1);
        chk("ovr_data", data_s, 8'h11);
        chk("ovr_valid", valid_s, 1);
        ready_s = 1'b1;
        tick(1);
        chk("ovr_drop", valid_s, 0);
        chk("ovr_bytes", rx_s.size() - base, 1);
        if (rx_s.size() > 0) chk("ovr_11", rx_s[rx_s.size() - 1], 8'h11);

        // Reset in the middle of data bit 4 abandons the frame.
        base = rx_s.size();
        send_s(8'hC3, 1'b1, 5);
        rxd_s = 1'b0;
        tick(4);
        reset = 1'b1;
        rxd_s = 1'b1;
        tick(1);
        chk("midrst_busy", busy_s, 0);
        chk("midrst_valid", valid_s, 0);
        chk("midrst_acc", u_s.acc_q, 0);
        reset = 1'b0;
        tick(2);
        send_s(8'h81, 1'b1, 10);
        tick(4);
        chk("midrst_bytes", rx_s.size() - base, 1);
        if (rx_s.size() > 0) chk("midrst_81", rx_s[rx_s.size() - 1], 8'h81);

        // Random frames with random gaps and occasional bad stop bits.
        ready_s = 1'b1;
        base = rx_s.size();
        fb = ferr_n_s;
        ob = ovr_n_s;
        nbad = 0;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            if (bad) nbad++;
            else exp_q.push_back(b);
            send_s(b, !bad, 10);
            rxd_s = 1'b1;
            tick(bad ? 4 + $urandom_range(0, 8) : $urandom_range(0, 8));
        end
        tick(4);
        chk("rnd_bytes", rx_s.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < rx_s.size())
                chk("rnd_byte", rx_s[base + i], exp_q[i]);
        end
        chk("rnd_ferr", ferr_n_s - fb, nbad);
        chk("rnd_ovr", ovr_n_s - ob, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
